// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command framer.
package uart_cmd_pkg;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, DRAIN} cmd_state_t;
endpackage

// File: rtl/uart_cmd_framer_if.sv
// RX character strobe, frame byte stream and status pulses of the command framer.
interface uart_cmd_framer_if;
   logic       rx_byte_en;
   logic [7:0] rx_byte;
   logic       frame_tvalid;
   logic       frame_tready;
   logic [7:0] frame_tdata;
   logic       frame_tlast;
   logic [8:0] frame_len;
   logic       busy;
   logic       err_char;
   logic       err_ovf;
   logic       err_drop;
   logic       err_tmo;

   modport master (
      input  rx_byte_en, rx_byte, frame_tready,
      output frame_tvalid, frame_tdata, frame_tlast, frame_len,
             busy, err_char, err_ovf, err_drop, err_tmo
   );
   modport slave (
      output rx_byte_en, rx_byte, frame_tready,
      input  frame_tvalid, frame_tdata, frame_tlast, frame_len,
             busy, err_char, err_ovf, err_drop, err_tmo
   );
endinterface

// File: rtl/uart_cmd_framer_hex_char_decode.sv
// Classifies one ASCII character as hex digit, separator or end-of-line.
module hex_char_decode
   import uart_cmd_pkg::*;
(
   input  logic [7:0] rx_byte,
   output logic       is_hex,
   output logic [3:0] nibble,
   output logic       is_sep,
   output logic       is_eol
);
   always_comb begin
      is_hex = 1'b0;
      nibble = 4'h0;
      if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
         is_hex = 1'b1;
         nibble = rx_byte[3:0];
      end else if ((rx_byte >= 8'h61 && rx_byte <= 8'h66) ||
                   (rx_byte >= 8'h41 && rx_byte <= 8'h46)) begin
         // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
         is_hex = 1'b1;
         nibble = rx_byte[3:0] + 4'd9;
      end
   end

   assign is_sep = (rx_byte == CH_SP) || (rx_byte == CH_CR);
   assign is_eol = (rx_byte == CH_LF);
endmodule

// File: rtl/uart_cmd_framer.sv
// Packs ASCII-hex command lines into binary frames and streams each frame out.
module uart_cmd_framer
   import uart_cmd_pkg::*;
#(
   parameter int MAX_LEN     = 64,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic              clk,
   input  logic              rstn,
   uart_cmd_framer_if.master bus
);
   localparam int AW = $clog2(MAX_LEN);
   localparam int CW = AW + 1;

   cmd_state_t    state, state_n;
   logic [CW-1:0] wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n, len, len_n;
   logic          pend, pend_n;
   logic [3:0]    hi, hi_n;
   logic [31:0]   idle_cnt;
   logic [7:0]    mem [MAX_LEN];
   logic          we, tmo, last;
   logic          e_char, e_ovf, e_drop, e_tmo;
   logic          q_char, q_ovf, q_drop, q_tmo;
   logic          is_hex, is_sep, is_eol;
   logic [3:0]    nib;

   hex_char_decode u_dec (
      .rx_byte (bus.rx_byte),
      .is_hex  (is_hex),
      .nibble  (nib),
      .is_sep  (is_sep),
      .is_eol  (is_eol)
   );

   assign tmo  = (state == COLLECT || state == DISCARD) && !bus.rx_byte_en &&
                 (idle_cnt >= 32'(TIMEOUT_CYC - 1));
   assign last = (rd_cnt == len - 1'b1);

   always_comb begin
      state_n  = state;
      wr_cnt_n = wr_cnt;
      rd_cnt_n = rd_cnt;
      len_n    = len;
      pend_n   = pend;
      hi_n     = hi;
      we       = 1'b0;
      e_char   = 1'b0;
      e_ovf    = 1'b0;
      e_drop   = 1'b0;
      e_tmo    = 1'b0;
      case (state)
         IDLE: if (bus.rx_byte_en) begin
            if (is_hex) begin
               hi_n    = nib;
               pend_n  = 1'b1;
               state_n = COLLECT;
            end else if (!is_sep && !is_eol) begin
               e_char  = 1'b1;
               state_n = DISCARD;
            end
         end
         COLLECT: if (tmo) begin
            e_tmo    = 1'b1;
            wr_cnt_n = '0;
            pend_n   = 1'b0;
            state_n  = IDLE;
         end else if (bus.rx_byte_en) begin
            if (is_hex) begin
               if (!pend) begin
                  hi_n   = nib;
                  pend_n = 1'b1;
               end else if (wr_cnt == CW'(MAX_LEN)) begin
                  e_ovf   = 1'b1;
                  pend_n  = 1'b0;
                  state_n = DISCARD;
               end else begin
                  we       = 1'b1;
                  wr_cnt_n = wr_cnt + 1'b1;
                  pend_n   = 1'b0;
               end
            end else if (is_sep) begin
               if (pend) begin
                  e_char  = 1'b1;
                  pend_n  = 1'b0;
                  state_n = DISCARD;
               end
            end else if (is_eol) begin
               // a dangling nibble kills the line; the EOL already ended it
               pend_n = 1'b0;
               if (pend) begin
                  e_char   = 1'b1;
                  wr_cnt_n = '0;
                  state_n  = IDLE;
               end else if (wr_cnt != '0) begin
                  len_n    = wr_cnt;
                  rd_cnt_n = '0;
                  state_n  = DRAIN;
               end else begin
                  state_n  = IDLE;
               end
            end else begin
               e_char  = 1'b1;
               pend_n  = 1'b0;
               state_n = DISCARD;
            end
         end
         DISCARD: if (tmo || (bus.rx_byte_en && is_eol)) begin
            e_tmo    = tmo;
            wr_cnt_n = '0;
            state_n  = IDLE;
         end
         DRAIN: begin
            e_drop = bus.rx_byte_en;
            if (bus.frame_tready) begin
               rd_cnt_n = rd_cnt + 1'b1;
               if (last) begin
                  wr_cnt_n = '0;
                  state_n  = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         len      <= '0;
         pend     <= 1'b0;
         hi       <= '0;
         idle_cnt <= '0;
         q_char   <= 1'b0;
         q_ovf    <= 1'b0;
         q_drop   <= 1'b0;
         q_tmo    <= 1'b0;
      end else begin
         state  <= state_n;
         wr_cnt <= wr_cnt_n;
         rd_cnt <= rd_cnt_n;
         len    <= len_n;
         pend   <= pend_n;
         hi     <= hi_n;
         q_char <= e_char;
         q_ovf  <= e_ovf;
         q_drop <= e_drop;
         q_tmo  <= e_tmo;
         if (bus.rx_byte_en || state == IDLE || state == DRAIN) idle_cnt <= '0;
         else if (idle_cnt != '1)                                idle_cnt <= idle_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wr_cnt[AW-1:0]] <= {hi, nib};
   end

   assign bus.frame_tvalid = (state == DRAIN);
   assign bus.frame_tdata  = (state == DRAIN) ? mem[rd_cnt[AW-1:0]] : 8'h00;
   assign bus.frame_tlast  = (state == DRAIN) && last;
   assign bus.frame_len    = 9'(len);
   assign bus.busy         = (state != IDLE);
   assign bus.err_char     = q_char;
   assign bus.err_ovf      = q_ovf;
   assign bus.err_drop     = q_drop;
   assign bus.err_tmo      = q_tmo;
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench: expected frame beats queued at stimulus time, popped per handshake.
module tb_uart_cmd_framer;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   uart_cmd_framer_if ifc ();

   uart_cmd_framer #(.MAX_LEN(4), .TIMEOUT_CYC(100)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (ifc)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int n_char = 0, n_ovf = 0, n_drop = 0, n_tmo = 0;
   int cyc = 0;
   logic [17:0] sb [$];
   int beat_t [$];
   logic        hold_v = 1'b0;
   logic [8:0]  hold_d;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] item(input bit lst, input int len, input logic [7:0] d);
      return {lst, 9'(len), d};
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rstn) begin
         if (ifc.err_char) n_char++;
         if (ifc.err_ovf)  n_ovf++;
         if (ifc.err_drop) n_drop++;
         if (ifc.err_tmo)  n_tmo++;
         if (hold_v && ifc.frame_tvalid)
            chk("hold", {ifc.frame_tlast, ifc.frame_tdata}, hold_d);
         hold_v = ifc.frame_tvalid && !ifc.frame_tready;
         hold_d = {ifc.frame_tlast, ifc.frame_tdata};
         if (ifc.frame_tvalid && ifc.frame_tready) begin
            beat_t.push_back(cyc);
            if (sb.size() == 0) chk("extra_beat", 1, 0);
            else chk("beat", {ifc.frame_tlast, ifc.frame_len, ifc.frame_tdata}, sb.pop_front());
         end
      end
   end

   task automatic send_char(input logic [7:0] c);
      @(posedge clk); #1;
      ifc.rx_byte_en = 1'b1;
      ifc.rx_byte    = c;
      @(posedge clk); #1;
      ifc.rx_byte_en = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("drain_left", sb.size(), 0);
   endtask

   task automatic chk_errs(input int c, input int o, input int d, input int t);
      chk("err_char", n_char, c);
      chk("err_ovf",  n_ovf,  o);
      chk("err_drop", n_drop, d);
      chk("err_tmo",  n_tmo,  t);
      n_char = 0; n_ovf = 0; n_drop = 0; n_tmo = 0;
      beat_t.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      ifc.rx_byte_en   = 1'b0;
      ifc.rx_byte      = 8'h00;
      ifc.frame_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", {ifc.frame_tvalid, ifc.frame_tlast, ifc.frame_tdata, ifc.frame_len,
                      ifc.busy, ifc.err_char, ifc.err_ovf, ifc.err_drop, ifc.err_tmo}, 0);
      rstn = 1'b1;

      // three back-to-back beats, first offered the cycle after EOL
      sb.push_back(item(0, 3, 8'hA5));
      sb.push_back(item(0, 3, 8'h0F));
      sb.push_back(item(1, 3, 8'h3C));
      send_str("a5 0F 3c\n");
      chk("lat", ifc.frame_tvalid, 1);
      wait_drain();
      chk("nbeats1", beat_t.size(), 3);
      if (beat_t.size() == 3) chk("b2b", beat_t[2] - beat_t[0], 2);
      chk("busy1", ifc.busy, 0);
      chk_errs(0, 0, 0, 0);

      // backpressure 1,0,0,1
      sb.push_back(item(0, 2, 8'h12));
      sb.push_back(item(1, 2, 8'h34));
      send_str("12 34\n");
      for (int i = 0; i < 4; i++) begin
         ifc.frame_tready = pat[i];
         @(posedge clk); #1;
      end
      chk("nbeats2", beat_t.size(), 2);
      chk("busy2", {ifc.busy, ifc.frame_tvalid}, 0);
      wait_drain();
      chk_errs(0, 0, 0, 0);

      // illegal character, then a good line
      send_str("1G2\n");
      repeat (3) @(posedge clk); #1;
      chk("nbeats3", beat_t.size(), 0);
      chk_errs(1, 0, 0, 0);
      sb.push_back(item(1, 1, 8'h77));
      send_str("77\n");
      wait_drain();
      chk("nbeats4", beat_t.size(), 1);
      chk_errs(0, 0, 0, 0);

      // odd nibble count, then empty lines
      send_str("123\n");
      repeat (3) @(posedge clk); #1;
      chk("busy5", ifc.busy, 0);
      chk_errs(1, 0, 0, 0);
      send_str("\n\r \n");
      repeat (3) @(posedge clk); #1;
      chk("nbeats6", beat_t.size(), 0);
      chk_errs(0, 0, 0, 0);

      // overflow at the fifth byte, then exactly MAX_LEN
      send_str("0102030405\n");
      repeat (3) @(posedge clk); #1;
      chk("nbeats7", beat_t.size(), 0);
      chk_errs(0, 1, 0, 0);
      sb.push_back(item(0, 4, 8'h01));
      sb.push_back(item(0, 4, 8'h02));
      sb.push_back(item(0, 4, 8'h03));
      sb.push_back(item(1, 4, 8'h04));
      send_str("01020304\n");
      wait_drain();
      chk("nbeats8", beat_t.size(), 4);
      chk_errs(0, 0, 0, 0);

      // inactivity timeout
      send_str("ab");
      repeat (90) @(posedge clk); #1;
      chk("tmo_early", {ifc.busy, 4'(n_tmo)}, {1'b1, 4'd0});
      repeat (12) @(posedge clk); #1;
      chk("busy_tmo", ifc.busy, 0);
      chk_errs(0, 0, 0, 1);

      // drops during DRAIN, including one on the final handshake
      ifc.frame_tready = 1'b0;
      sb.push_back(item(1, 1, 8'h5A));
      send_str("5a\n");
      send_char(8'h78);
      @(posedge clk); #1;
      ifc.frame_tready = 1'b1;
      ifc.rx_byte_en   = 1'b1;
      ifc.rx_byte      = 8'h71;
      @(posedge clk); #1;
      ifc.rx_byte_en   = 1'b0;
      sb.push_back(item(1, 1, 8'h66));
      send_str("66\n");
      wait_drain();
      chk("nbeats9", beat_t.size(), 2);
      chk_errs(0, 0, 2, 0);

      // reset mid-line
      send_str("77");
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid", {ifc.busy, ifc.frame_tvalid, ifc.frame_len}, 0);
      rstn = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Controller that sits directly behind the UART byte receiver (receiver outputs `uart_rx_byte_en` / `uart_rx_byte[7:0]`).
- Parses ASCII-hex command lines typed by the host, packs them into binary frames in an internal buffer, and releases each frame to the NFC transmit path as a valid/ready byte stream.
- Handles line framing, illegal characters, overflow and host inactivity, so downstream logic only ever sees complete, well-formed frames.

Parameters:
- MAX_LEN, 64, maximum number of binary bytes per frame (power of 2, 2..256).
- TIMEOUT_CYC, 50000000, clk cycles of RX inactivity after which a partial line is abandoned.

Ports:
- clk  input  1  system clock.
- rstn  input  1  synchronous active-low reset.
- rx_byte_en  input  1  one-cycle strobe, rx_byte valid.
- rx_byte  input  8  received ASCII character.
- frame_tvalid  output  1  output byte valid.
- frame_tready  input  1  downstream accepts byte.
- frame_tdata  output  8  output frame byte.
- frame_tlast  output  1  marks last byte of frame.
- frame_len  output  9  byte count of frame being drained (1..MAX_LEN), stable during DRAIN.
- busy  output  1  high in COLLECT, DRAIN or DISCARD.
- err_char  output  1  one-cycle pulse: illegal character or odd nibble count.
- err_ovf  output  1  one-cycle pulse: frame exceeded MAX_LEN.
- err_drop  output  1  one-cycle pulse: character received during DRAIN and dropped.
- err_tmo  output  1  one-cycle pulse: inactivity timeout.

Behaviour:
- Reset (rstn=0 at posedge clk), whatever the current state:
  - State goes to IDLE; all counters and the pending-nibble register clear.
  - All outputs return to 0: frame_tvalid, frame_tlast, frame_tdata, frame_len, busy, all err_* pulses.
- Character classes:
  - HEX: 0-9, a-f, A-F.
  - SEP: 0x20 (space) and 0x0D (carriage return).
  - EOL: 0x0A.
  - Anything else is ILLEGAL.
- Nibble packing:
  - The first HEX character of a pair is held as the high nibble; the second completes the byte {hi,lo}.
  - The completed byte is written to buffer[wr_cnt], then wr_cnt increments.
- IDLE:
  - HEX -> store the nibble, go to COLLECT.
  - SEP or EOL -> ignored, stay IDLE (empty lines produce no frame).
  - ILLEGAL -> pulse err_char, go to DISCARD.
- COLLECT:
  - HEX -> pack as above. If the completed byte would make wr_cnt exceed MAX_LEN: pulse err_ovf, go to DISCARD, buffer contents unchanged.
  - SEP with nibble pending -> pulse err_char, go to DISCARD. SEP with no nibble pending -> ignored.
  - EOL with nibble pending -> pulse err_char, go to IDLE (line already terminated).
  - EOL with no nibble pending and wr_cnt>0 -> latch frame_len=wr_cnt, rd_cnt=0, go to DRAIN.
  - ILLEGAL -> pulse err_char, go to DISCARD.
  - Timeout: the idle counter resets on every rx_byte_en. When it reaches TIMEOUT_CYC-1 without a character: pulse err_tmo, clear wr_cnt and the pending nibble, go to IDLE.
- DISCARD:
  - Ignore everything until EOL, then clear wr_cnt and go to IDLE.
  - No further err_char / err_ovf pulses for the same line.
  - Timeout also applies here: pulse err_tmo, go to IDLE.
- DRAIN:
  - frame_tvalid=1 from the cycle after the EOL strobe.
  - frame_tdata = buffer[rd_cnt]; frame_tlast = (rd_cnt == frame_len-1).
  - tdata and tlast hold stable while tvalid && !tready.
  - On tvalid && tready: rd_cnt++. If tlast: the same edge drops tvalid, clears wr_cnt, goes to IDLE.
  - Minimum latency EOL strobe -> first byte offered: 1 cycle. Throughput: 1 byte/cycle when tready is held high.
  - Any rx_byte_en during DRAIN pulses err_drop; the character is discarded, including EOL. No queueing.
  - Timeout is disabled in DRAIN; downstream backpressure may be unbounded.
- Simultaneous events:
  - rx_byte_en in the same cycle as the final handshake of DRAIN is still dropped (err_drop). The next character is processed in IDLE.
- Widths:
  - wr_cnt, rd_cnt and frame_len are $clog2(MAX_LEN)+1 bits, zero-extended to the 9-bit frame_len port.
  - The idle counter is 32 bits, saturating.
- Buffer: MAX_LEN x 8 register array, written in COLLECT, read combinationally in DRAIN. Contents need not be reset.

Decomposition:
- Package uart_cmd_pkg:
  - ASCII constants CH_SP=8'h20, CH_CR=8'h0D, CH_LF=8'h0A.
  - typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, DRAIN} cmd_state_t.
- One sub-module, hex_char_decode (combinational): rx_byte -> is_hex, nibble[3:0], is_sep, is_eol.
- The FSM, counters and buffer stay in uart_cmd_framer.

Test Plan:
- "a5 0F 3c\n" with tready=1 -> 3 consecutive beats A5, 0F, 3C; tlast on 3C; frame_len=3; no err pulses.
- "12 34\n" with tready toggling 1,0,0,1 -> tdata held at 34 across stalled cycles; exactly 2 handshakes; busy low after the tlast handshake.
- "1G2\n" -> err_char single pulse at 'G'; no tvalid; following "77\n" yields one frame {77}.
- "123\n" -> err_char at EOL, no frame. Then "\n\r \n" -> no frame and no errors.
- MAX_LEN=4, "0102030405\n" -> err_ovf at the 5th byte, no frame. "01020304\n" -> 4-beat frame.
- TIMEOUT_CYC=100: "ab" then 100 idle cycles -> err_tmo, state IDLE. A character sent during DRAIN -> err_drop, frame unaffected.
